// File: rtl/cpu_host_bridge_pkg.sv
// Shared types and constants for the CPU host bridge.
// Optional feature macro: LOAD_CHECKSUM_EN (adds load_sum / sum_ok on the top).
package cpu_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_RSVD = 2'b11;

  localparam int DEF_BUF_BASE  = 1500;
  localparam int DEF_BUF_DEPTH = 108;
  localparam int DEF_INJ_REG   = 6;
  localparam int DEF_DONE_REG  = 28;

  // The reserved command code behaves exactly like idle.
  function automatic logic cmdIsIdle(input logic [1:0] cmd);
    return (cmd == CMD_IDLE) || (cmd == CMD_RSVD);
  endfunction

endpackage

// File: rtl/cpu_host_bridge_if.sv
// Host-side bus of the CPU host bridge: command, byte stream, parameter,
// program select and RAM readback. The board drives the master side.
// Optional feature macro: LOAD_CHECKSUM_EN (does not affect this interface).
interface cpu_host_bridge_if #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int CHAR_W  = 8,
  parameter int PARAM_W = 5,
  parameter int PSEL_W  = 2
);
  logic [1:0]         host_cmd;
  logic               host_valid;
  logic               host_ready;
  logic [CHAR_W-1:0]  host_data;
  logic [PARAM_W-1:0] host_param;
  logic [PSEL_W-1:0]  prog_sel;
  logic [ADDR_W-1:0]  host_rd_addr;
  logic [DATA_W-1:0]  host_rd_data;

  modport master (
    output host_cmd, host_valid, host_data, host_param, prog_sel, host_rd_addr,
    input  host_ready, host_rd_data
  );

  modport slave (
    input  host_cmd, host_valid, host_data, host_param, prog_sel, host_rd_addr,
    output host_ready, host_rd_data
  );
endinterface

// File: rtl/cpu_host_bridge_reg_inject_arb.sv
// Regfile write arbiter: injects the host parameter into a fixed register
// whenever it changes, yielding to CPU writes without ever losing the value.
// Optional feature macro: LOAD_CHECKSUM_EN (does not affect this module).
module reg_inject_arb
  import cpu_host_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PARAM_W = 5,
  parameter int INJ_REG = DEF_INJ_REG
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PARAM_W-1:0] i_hostParam,
  input  logic               i_cpuRwe,
  input  logic [4:0]         i_cpuRd,
  input  logic [DATA_W-1:0]  i_cpuRdata,
  output logic               o_rfWe,
  output logic [4:0]         o_rfRd,
  output logic [DATA_W-1:0]  o_rfWdata
);

  logic [PARAM_W-1:0] r_param;
  logic               r_pending;
  logic               r_fresh;
  logic               w_change;

  // r_fresh makes the first cycle after reset count as a change.
  assign w_change = r_fresh || (i_hostParam != r_param);

  // Register the parameter; a change (re)arms pending, an idle CPU port drains it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_param   <= '0;
      r_pending <= 1'b0;
      r_fresh   <= 1'b1;
    end else begin
      r_param <= i_hostParam;
      r_fresh <= 1'b0;
      if (w_change) begin
        r_pending <= 1'b1;
      end else if (!i_cpuRwe) begin
        r_pending <= 1'b0;
      end
    end
  end

  // CPU write has priority; the latest registered value goes out otherwise.
  always_comb begin
    o_rfWe    = i_cpuRwe || r_pending;
    o_rfRd    = i_cpuRd;
    o_rfWdata = i_cpuRdata;
    if (!i_cpuRwe && r_pending) begin
      o_rfRd    = 5'(INJ_REG);
      o_rfWdata = DATA_W'(r_param);
    end
  end

endmodule

// File: rtl/cpu_host_bridge.sv
// Host arbiter for the decryption CPU: load ciphertext into RAM, run the
// selected program, detect completion and open RAM readback.
// Optional feature macro: LOAD_CHECKSUM_EN (load_sum / sum_ok outputs and a
// one-cycle RAM check on completion).
module cpu_host_bridge
  import cpu_host_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int CHAR_W    = 8,
  parameter int PARAM_W   = 5,
  parameter int BUF_BASE  = DEF_BUF_BASE,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int NUM_PROG  = 2,
  parameter int PSEL_W    = $clog2(NUM_PROG + 1),
  parameter int INJ_REG   = DEF_INJ_REG,
  parameter int DONE_REG  = DEF_DONE_REG
) (
  input  logic               clock,
  input  logic               reset,
  cpu_host_bridge_if.slave   host,
  output logic [7:0]         load_count,
  output logic [PSEL_W-1:0]  imem_sel,
  output logic               cpu_reset,
  output logic               done,
  input  logic               cpu_mwe,
  input  logic [ADDR_W-1:0]  cpu_maddr,
  input  logic [DATA_W-1:0]  cpu_mdata,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata,
  input  logic               cpu_rwe,
  input  logic [4:0]         cpu_rd,
  input  logic [DATA_W-1:0]  cpu_rdata,
  output logic               rf_we,
  output logic [4:0]         rf_rd,
  output logic [DATA_W-1:0]  rf_wdata
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [15:0]        load_sum,
  output logic               sum_ok
`endif
);

  state_t              r_state;
  logic [7:0]          r_loadCount;
  logic [PSEL_W-1:0]   r_imemSel;
  logic                r_cpuReset;
  logic                r_done;

  logic [CHAR_W-1:0]   w_byte;
  logic [ADDR_W-1:0]   w_bufAddr;
  logic                w_ready;
  logic                w_accept;
  logic                w_cmdIdle;
  logic                w_doneWrite;
  logic                w_enterLoad;
  logic                w_enterRun;
  logic                w_enterDone;
  logic                w_chkAddr;

  assign w_byte      = host.host_data;
  assign w_bufAddr   = ADDR_W'(BUF_BASE) + ADDR_W'(r_loadCount);
  assign w_ready     = (r_state == ST_LOAD) && (r_loadCount < 8'(BUF_DEPTH));
  assign w_accept    = w_ready && host.host_valid;
  assign w_cmdIdle   = cmdIsIdle(host.host_cmd);
  assign w_doneWrite = (r_state == ST_RUN) && cpu_rwe && (cpu_rd == 5'(DONE_REG))
                       && (cpu_rdata == DATA_W'(1));
  assign w_enterLoad = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && (host.host_cmd == CMD_LOAD);
  assign w_enterRun  = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) && (host.host_cmd == CMD_RUN);
  assign w_enterDone = w_doneWrite && !w_cmdIdle;

  // Main sequencer: state, load counter, latched image select and CPU control.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_loadCount <= '0;
      r_imemSel   <= '0;
      r_cpuReset  <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_loadCount <= r_loadCount + 8'd1;
      end
      if (w_enterLoad) begin
        r_loadCount <= '0;
      end
      if (w_cmdIdle) begin
        r_state    <= ST_IDLE;
        r_cpuReset <= 1'b1;
      end else if (w_enterLoad) begin
        r_state <= ST_LOAD;
      end else if (w_enterRun) begin
        r_state    <= ST_RUN;
        r_imemSel  <= host.prog_sel;
        r_done     <= 1'b0;
        r_cpuReset <= 1'b0;
      end else if (w_enterDone) begin
        r_state    <= ST_DONE;
        r_done     <= 1'b1;
        r_cpuReset <= 1'b1;
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [15:0] r_loadSum;
  logic [1:0]  r_chkPhase;
  logic        r_sumOk;

  // Running byte sum and the one-shot compare against the CPU's result word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_loadSum  <= '0;
      r_chkPhase <= 2'd0;
      r_sumOk    <= 1'b0;
    end else begin
      if (w_enterLoad) begin
        r_loadSum <= '0;
      end else if (w_accept) begin
        r_loadSum <= r_loadSum + 16'(w_byte);
      end
      if (w_enterDone) begin
        r_chkPhase <= 2'd1;
        r_sumOk    <= 1'b0;
      end else if (r_chkPhase == 2'd1) begin
        r_chkPhase <= 2'd2;
      end else if (r_chkPhase == 2'd2) begin
        r_chkPhase <= 2'd0;
        r_sumOk    <= (ram_rdata == DATA_W'(r_loadSum));
      end
    end
  end

  assign load_sum  = r_loadSum;
  assign sum_ok    = r_sumOk && (r_state == ST_DONE);
  assign w_chkAddr = (r_state == ST_DONE) && (r_chkPhase == 2'd1);
`else
  assign w_chkAddr = 1'b0;
`endif

  // RAM port owner: host loader, CPU passthrough, or host readback.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = host.host_rd_addr;
    ram_wdata = '0;
    case (r_state)
      ST_LOAD: begin
        ram_we    = w_accept;
        ram_addr  = w_bufAddr;
        ram_wdata = DATA_W'(w_byte);
      end
      ST_RUN: begin
        ram_we    = cpu_mwe;
        ram_addr  = cpu_maddr;
        ram_wdata = cpu_mdata;
      end
      ST_DONE: begin
        if (w_chkAddr) begin
          ram_addr = ADDR_W'(BUF_BASE + BUF_DEPTH);
        end
      end
      default: begin
      end
    endcase
  end

  assign host.host_ready   = w_ready;
  assign host.host_rd_data = ram_rdata;
  assign load_count        = r_loadCount;
  assign imem_sel          = r_imemSel;
  assign cpu_reset         = r_cpuReset;
  assign done              = r_done;

  reg_inject_arb #(
    .DATA_W  (DATA_W),
    .PARAM_W (PARAM_W),
    .INJ_REG (INJ_REG)
  ) u_injectArb (
    .clock       (clock),
    .reset       (reset),
    .i_hostParam (host.host_param),
    .i_cpuRwe    (cpu_rwe),
    .i_cpuRd     (cpu_rd),
    .i_cpuRdata  (cpu_rdata),
    .o_rfWe      (rf_we),
    .o_rfRd      (rf_rd),
    .o_rfWdata   (rf_wdata)
  );

endmodule

// File: tb/tb_cpu_host_bridge.sv
// Self-checking bench for cpu_host_bridge: randomized load/inject stimulus
// against a behavioural model, plus directed run/done/abort/reset scenarios.
module tb_cpu_host_bridge;
  import cpu_host_pkg::*;

  localparam int BUF_BASE  = 1500;
  localparam int BUF_DEPTH = 108;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  cpu_host_bridge_if hif ();

  logic [7:0]  load_count;
  logic [1:0]  imem_sel;
  logic        cpu_reset;
  logic        done;
  logic        cpu_mwe;
  logic [11:0] cpu_maddr;
  logic [31:0] cpu_mdata;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        cpu_rwe;
  logic [4:0]  cpu_rd;
  logic [31:0] cpu_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
`ifdef LOAD_CHECKSUM_EN
  logic [15:0] load_sum;
  logic        sum_ok;
`endif

  cpu_host_bridge dut (
    .clock      (clock),
    .reset      (reset),
    .host       (hif),
    .load_count (load_count),
    .imem_sel   (imem_sel),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .cpu_mwe    (cpu_mwe),
    .cpu_maddr  (cpu_maddr),
    .cpu_mdata  (cpu_mdata),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .cpu_rwe    (cpu_rwe),
    .cpu_rd     (cpu_rd),
    .cpu_rdata  (cpu_rdata),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata)
`ifdef LOAD_CHECKSUM_EN
    ,
    .load_sum   (load_sum),
    .sum_ok     (sum_ok)
`endif
  );

  // Synchronous-read RAM; every word starts with a recognisable pattern.
  logic [31:0] mem [0:4095];
  bit          memReady;

  always @(posedge clock) begin
    if (!memReady) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      memReady <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  int checks   = 0;
  int failures = 0;

  logic [7:0]  expBuf [0:BUF_DEPTH-1];
  logic [31:0] cpuWord;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] cmd, input logic valid, input logic [7:0] data);
    @(posedge clock);
    #1;
    hif.host_cmd   = cmd;
    hif.host_valid = valid;
    hif.host_data  = data;
  endtask

  task automatic readCheck(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    applyStimulus(hif.host_cmd, 1'b0, 8'h00);
    hif.host_rd_addr = addr;
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput(tag, 64'(hif.host_rd_data), 64'(exp));
  endtask

  task automatic checkRf(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
    if (we) checkOutput(tag, {26'd0, rf_we, rf_rd, rf_wdata}, {26'd0, we, rd, data});
    else    checkOutput(tag, 64'(rf_we), 64'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         offered;
    int         expCount;
    logic       v;
    logic [7:0] d;
    logic [4:0] p;
    logic [4:0] regParam;
    logic       modelPend;
    logic [4:0] modelVal;
    logic       rwe;
    logic [4:0] rd;
    logic [31:0] rdat;

    reset            = 1'b1;
    hif.host_cmd     = CMD_IDLE;
    hif.host_valid   = 1'b0;
    hif.host_data    = 8'h00;
    hif.host_param   = 5'd0;
    hif.prog_sel     = 2'd0;
    hif.host_rd_addr = 12'd0;
    cpu_mwe   = 1'b0;
    cpu_maddr = 12'd0;
    cpu_mdata = 32'd0;
    cpu_rwe   = 1'b0;
    cpu_rd    = 5'd0;
    cpu_rdata = 32'd0;

    // Reset values
    #3;
    checkOutput("rst_ready", 64'(hif.host_ready), 64'(0));
    checkOutput("rst_count", 64'(load_count), 64'(0));
    checkOutput("rst_imem", 64'(imem_sel), 64'(0));
    checkOutput("rst_cpureset", 64'(cpu_reset), 64'(1));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_ramwe", 64'(ram_we), 64'(0));
    checkOutput("rst_rfwe", 64'(rf_we), 64'(0));

    @(negedge clock);
    #2;
    reset = 1'b0;
    // Reset release counts as a parameter change: r6 <= 0 one cycle later
    @(negedge clock);
    checkRf("rel_inject", 1'b1, 5'd6, 32'd0);
    @(negedge clock);
    checkRf("rel_inject_once", 1'b0, 5'd0, 32'd0);

    // Overflow: 110 offered bytes with random valid gaps
    applyStimulus(CMD_LOAD, 1'b0, 8'h00);
    offered  = 0;
    expCount = 0;
    for (int it = 0; it < 2000 && offered < 110; it++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      applyStimulus(CMD_LOAD, v, d);
      @(negedge clock);
      checkOutput("ovf_ready", 64'(hif.host_ready), 64'(expCount < BUF_DEPTH));
      checkOutput("ovf_we", 64'(ram_we), 64'(v && (expCount < BUF_DEPTH)));
      if (v && (expCount < BUF_DEPTH)) begin
        checkOutput("ovf_addr", 64'(ram_addr), 64'(BUF_BASE + expCount));
        expBuf[expCount] = d;
        expCount++;
      end
      if (v) offered++;
    end
    checkOutput("ovf_offered", 64'(offered), 64'(110));
    applyStimulus(CMD_LOAD, 1'b0, 8'h00);
    @(negedge clock);
    checkOutput("ovf_count", 64'(load_count), 64'(BUF_DEPTH));
    for (int k = 0; k < BUF_DEPTH; k++) begin
      checkOutput("ovf_ram", 64'(mem[BUF_BASE + k]), 64'({24'd0, expBuf[k]}));
    end
    checkOutput("ovf_ram1608", 64'(mem[1608]), 64'(32'hA500_0648));

    // Readback in IDLE
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    readCheck("idle_rb", 12'd1505, {24'd0, expBuf[5]});

    // Load 0x41..0x43 from a fresh LOAD entry
    applyStimulus(CMD_LOAD, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      d = 8'h41 + 8'(k);
      applyStimulus(CMD_LOAD, 1'b1, d);
      @(negedge clock);
      checkOutput("load_we", 64'(ram_we), 64'(1));
      checkOutput("load_addr", 64'(ram_addr), 64'(BUF_BASE + k));
      checkOutput("load_wdata", 64'(ram_wdata), 64'(d));
      expBuf[k] = d;
    end
    applyStimulus(CMD_LOAD, 1'b0, 8'h00);
    @(negedge clock);
    checkOutput("load_count3", 64'(load_count), 64'(3));

    // Run with image 2; image select ignored during RUN
    hif.prog_sel = 2'd2;
    applyStimulus(CMD_RUN, 1'b0, 8'h00);
    applyStimulus(CMD_RUN, 1'b1, 8'h99);
    hif.prog_sel = 2'd1;
    @(negedge clock);
    checkOutput("run_imem", 64'(imem_sel), 64'(2));
    checkOutput("run_cpureset", 64'(cpu_reset), 64'(0));
    checkOutput("run_done", 64'(done), 64'(0));
    checkOutput("run_ready", 64'(hif.host_ready), 64'(0));
    cpuWord = $urandom;
    applyStimulus(CMD_RUN, 1'b0, 8'h00);
    cpu_mwe   = 1'b1;
    cpu_maddr = 12'd100;
    cpu_mdata = cpuWord;
    @(negedge clock);
    checkOutput("run_pass", {ram_we, 19'd0, ram_addr, ram_wdata}, {1'b1, 19'd0, 12'd100, cpuWord});
    applyStimulus(CMD_RUN, 1'b0, 8'h00);
    cpu_mwe   = 1'b0;
    cpu_rwe   = 1'b1;
    cpu_rd    = 5'd28;
    cpu_rdata = 32'd1;
    @(negedge clock);
    checkRf("done_write_rf", 1'b1, 5'd28, 32'd1);
    checkOutput("done_not_yet", 64'(done), 64'(0));
    applyStimulus(CMD_RUN, 1'b0, 8'h00);
    cpu_rwe = 1'b0;
    cpu_mwe = 1'b1;
    @(negedge clock);
    checkOutput("done_set", 64'(done), 64'(1));
    checkOutput("done_cpureset", 64'(cpu_reset), 64'(1));
    checkOutput("done_ramwe", 64'(ram_we), 64'(0));
    checkOutput("done_imem", 64'(imem_sel), 64'(2));
    cpu_mwe = 1'b0;
    readCheck("done_rb1500", 12'd1500, 32'h41);
    readCheck("done_rb100", 12'd100, cpuWord);
    readCheck("done_rb1608", 12'd1608, 32'hA500_0648);

    // Reserved command leaves DONE; done is sticky until the next run
    applyStimulus(CMD_RSVD, 1'b0, 8'h00);
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    @(negedge clock);
    checkOutput("idle_done_sticky", 64'(done), 64'(1));

    // Abort mid-run
    applyStimulus(CMD_RUN, 1'b0, 8'h00);
    applyStimulus(CMD_RUN, 1'b0, 8'h00);
    @(negedge clock);
    checkOutput("abort_run_done", 64'(done), 64'(0));
    checkOutput("abort_run_cpureset", 64'(cpu_reset), 64'(0));
    checkOutput("abort_run_imem", 64'(imem_sel), 64'(1));
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    @(negedge clock);
    checkOutput("abort_same_cycle", 64'(cpu_reset), 64'(0));
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    @(negedge clock);
    checkOutput("abort_cpureset", 64'(cpu_reset), 64'(1));
    checkOutput("abort_done", 64'(done), 64'(0));
    readCheck("abort_ram", 12'd1500, 32'h41);

    // Injection collides with three CPU writes
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    hif.host_param = 5'd5;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) applyStimulus(CMD_IDLE, 1'b0, 8'h00);
      cpu_rwe   = 1'b1;
      cpu_rd    = 5'd3;
      cpu_rdata = $urandom;
      @(negedge clock);
      checkRf("coll_cpu", 1'b1, 5'd3, cpu_rdata);
    end
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    cpu_rwe = 1'b0;
    @(negedge clock);
    checkRf("coll_inject", 1'b1, 5'd6, 32'd5);
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    @(negedge clock);
    checkRf("coll_once", 1'b0, 5'd0, 32'd0);

    // Two changes while blocked -> single write of the latest value
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    hif.host_param = 5'd9;
    cpu_rwe = 1'b1;
    cpu_rd  = 5'd4;
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    hif.host_param = 5'd17;
    @(negedge clock);
    checkRf("dbl_cpu", 1'b1, 5'd4, cpu_rdata);
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    cpu_rwe = 1'b0;
    @(negedge clock);
    checkRf("dbl_inject", 1'b1, 5'd6, 32'd17);
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    @(negedge clock);
    checkRf("dbl_once", 1'b0, 5'd0, 32'd0);

    // Zero is injected like any other value
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    hif.host_param = 5'd0;
    @(negedge clock);
    checkRf("zero_wait", 1'b0, 5'd0, 32'd0);
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    @(negedge clock);
    checkRf("zero_inject", 1'b1, 5'd6, 32'd0);
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    @(negedge clock);
    checkRf("zero_once", 1'b0, 5'd0, 32'd0);

    // Random parameter changes against random CPU traffic
    regParam  = 5'd0;
    modelPend = 1'b0;
    modelVal  = 5'd0;
    for (int c = 0; c < 80; c++) begin
      p    = ($urandom_range(0, 2) == 0) ? 5'($urandom) : regParam;
      rwe  = 1'($urandom);
      rd   = 5'($urandom);
      rdat = $urandom;
      applyStimulus(CMD_IDLE, 1'b0, 8'h00);
      hif.host_param = p;
      cpu_rwe   = rwe;
      cpu_rd    = rd;
      cpu_rdata = rdat;
      @(negedge clock);
      if (rwe)            checkRf("rnd_cpu", 1'b1, rd, rdat);
      else if (modelPend) checkRf("rnd_inject", 1'b1, 5'd6, {27'd0, modelVal});
      else                checkRf("rnd_quiet", 1'b0, 5'd0, 32'd0);
      if (p != regParam) begin
        modelPend = 1'b1;
        modelVal  = p;
      end else if (modelPend && !rwe) begin
        modelPend = 1'b0;
      end
      regParam = p;
    end
    applyStimulus(CMD_IDLE, 1'b0, 8'h00);
    cpu_rwe = 1'b0;

    // Asynchronous reset between edges in the middle of a load
    applyStimulus(CMD_LOAD, 1'b0, 8'h00);
    applyStimulus(CMD_LOAD, 1'b1, 8'h11);
    applyStimulus(CMD_LOAD, 1'b1, 8'h22);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_count", 64'(load_count), 64'(0));
    checkOutput("areset_ready", 64'(hif.host_ready), 64'(0));
    checkOutput("areset_ramwe", 64'(ram_we), 64'(0));
    checkOutput("areset_imem", 64'(imem_sel), 64'(0));
    checkOutput("areset_cpureset", 64'(cpu_reset), 64'(1));
    checkOutput("areset_done", 64'(done), 64'(0));
    checkOutput("areset_rfwe", 64'(rf_we), 64'(0));
    @(negedge clock);
    hif.host_valid = 1'b0;
    hif.host_cmd   = CMD_IDLE;
    reset = 1'b0;
    repeat (2) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
